polarfir_hls_deadlock_confirm_unit: RTL and testbench

Per-process deadlock detection unit with persistence filtering, for HLS dataflow regions in the polarFir design. It keeps the existing dependence-propagation and token-passing behaviour and adds a debounce stage: a dependence cycle through this process must persist for `CONFIRM_CYCLES` consecutive cycles before it is reported. A confirmed report latches until cleared and records which output channels were blocked. One instance sits per dataflow process, chained to its neighbours through the dependence and token vectors.

---
 rtl/polarfir_hls_deadlock_confirm_unit.sv | 181 ++++++++++++++++++
 tb/tb_polarfir_hls_deadlock_confirm_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/polarfir_hls_deadlock_confirm_unit.sv
// polarfir_hls_deadlock_confirm_unit
//
// Per-process deadlock detector for an HLS dataflow region, with a
// persistence (debounce) filter on the raw detection. It merges incoming
// dependence vectors and raises a raw suspect when a dependence cycle comes
// back to this process. The raw suspect must hold for CONFIRM_CYCLES
// consecutive cycles before it becomes a confirmed report. The report
// latches until token_clear.
//
// State table:
//   state        | meaning
//   -------------+-----------------------------------------------------
//   ST_IDLE      | no raw detection in the previous cycle, counter at zero
//   ST_SUSPECT   | raw detection seen for r_cnt consecutive cycles
//   ST_CONFIRMED | deadlock confirmed; raw ignored until token_clear
//
// Ports:
//   clock, reset            : clock (rising edge), async active-low reset
//   proc_dep_vld_vec        : this process is blocked on output channel k
//   in_chan_dep_vld_vec     : dependence valid per input channel
//   in_chan_dep_data_vec    : dependence vector per input channel
//   token_in_vec            : report token per input channel
//   dl_detect_in            : a deadlock is already flagged in the region
//   origin                  : this process originates the report token
//   token_clear             : clears the token, acknowledges a report
//   out_chan_dep_vld_vec    : pass-through of proc_dep_vld_vec
//   out_chan_dep_data       : registered dependence vector plus own bit
//   token_out_vec           : registered report token per output channel
//   dl_suspect              : raw, unfiltered detection (combinational)
//   dl_detect_out           : confirmed deadlock
//   dl_chan_vec             : blocked output channels at confirmation
//   dl_sticky               : a confirmation has occurred since reset

module polarfir_hls_deadlock_confirm_unit #(
    parameter int PROC_NUM       = 4,
    parameter int PROC_ID        = 0,
    parameter int IN_CHAN_NUM    = 2,
    parameter int OUT_CHAN_NUM   = 3,
    parameter int CONFIRM_CYCLES = 16,
    parameter int CNT_W          = $clog2(CONFIRM_CYCLES + 1)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
    input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
    input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
    input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
    input  logic                            dl_detect_in,
    input  logic                            origin,
    input  logic                            token_clear,
    output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
    output logic [PROC_NUM-1:0]             out_chan_dep_data,
    output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
    output logic                            dl_suspect,
    output logic                            dl_detect_out,
    output logic [OUT_CHAN_NUM-1:0]         dl_chan_vec,
    output logic                            dl_sticky
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SUSPECT   = 2'd1,
        ST_CONFIRMED = 2'd2
    } state_t;

    localparam logic [PROC_NUM-1:0] LP_SELF = PROC_NUM'(1) << PROC_ID;
    // Last count value before confirmation; the counter never reaches
    // CONFIRM_CYCLES itself, so it cannot wrap.
    localparam logic [CNT_W-1:0]    LP_LAST = CNT_W'(CONFIRM_CYCLES - 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         w_cnt_nxt;
    logic                     w_confirm;

    logic [PROC_NUM-1:0]      r_dep_reg;
    logic [PROC_NUM-1:0]      w_dep_comb;
    logic [PROC_NUM-1:0]      w_dep;
    logic                     w_gate;
    logic                     w_blocked;
    logic                     w_raw;
    logic                     w_tok_en;

    logic [OUT_CHAN_NUM-1:0]  r_token_out;
    logic [OUT_CHAN_NUM-1:0]  r_dl_chan;
    logic                     r_dl_sticky;

    always_comb begin
        w_dep_comb = '0;
        for (int i = 0; i < IN_CHAN_NUM; i++) begin
            if (in_chan_dep_vld_vec[i]) begin
                w_dep_comb = w_dep_comb | in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM];
            end
        end
    end

    // Once a deadlock is flagged elsewhere, the dependence vector is frozen
    // unless a report token arrives on one of the input channels.
    assign w_gate    = ~dl_detect_in | (|token_in_vec);
    assign w_dep     = w_gate ? w_dep_comb : r_dep_reg;
    assign w_blocked = |proc_dep_vld_vec;
    assign w_raw     = w_gate & w_dep[PROC_ID] & w_blocked;
    // origin overrides token_clear.
    assign w_tok_en  = ((|token_in_vec) & ~token_clear) | origin;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_confirm   = 1'b0;
        case (r_state)
            ST_IDLE, ST_SUSPECT: begin
                if (w_raw) begin
                    if (r_cnt == LP_LAST) begin
                        w_state_nxt = ST_CONFIRMED;
                        w_cnt_nxt   = '0;
                        w_confirm   = 1'b1;
                    end else begin
                        w_state_nxt = ST_SUSPECT;
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end
                end else begin
                    // Any gap in the raw detection restarts the count.
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_CONFIRMED: begin
                if (token_clear) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        dl_detect_out = (r_state == ST_CONFIRMED);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_dep_reg   <= '0;
            r_token_out <= '0;
            r_dl_chan   <= '0;
            r_dl_sticky <= 1'b0;
        end else begin
            r_dep_reg   <= w_blocked ? w_dep : '0;
            r_token_out <= w_tok_en ? proc_dep_vld_vec : '0;
            if (w_confirm) begin
                r_dl_chan   <= proc_dep_vld_vec;
                r_dl_sticky <= 1'b1;
            end
        end
    end

    assign out_chan_dep_vld_vec = proc_dep_vld_vec;
    assign out_chan_dep_data    = r_dep_reg | LP_SELF;
    assign token_out_vec        = r_token_out;
    assign dl_suspect           = w_raw;
    assign dl_chan_vec          = r_dl_chan;
    assign dl_sticky            = r_dl_sticky;

endmodule

// File: tb/tb_polarfir_hls_deadlock_confirm_unit.sv
module tb_polarfir_hls_deadlock_confirm_unit;

    localparam int PN = 4;
    localparam int PID = 0;
    localparam int INC = 2;
    localparam int OUTC = 3;
    localparam int CC = 4;

    logic            clk;
    logic            rst_n;
    logic [OUTC-1:0] pdv;
    logic [INC-1:0]  vld;
    logic [INC*PN-1:0] data;
    logic [INC-1:0]  tin;
    logic            dlin;
    logic            orig;
    logic            clr;
    logic [OUTC-1:0] ovld;
    logic [PN-1:0]   odata;
    logic [OUTC-1:0] otok;
    logic            osus;
    logic            odet;
    logic [OUTC-1:0] ochan;
    logic            ostk;

    int checks = 0;
    int errors = 0;

    polarfir_hls_deadlock_confirm_unit #(
        .PROC_NUM(PN), .PROC_ID(PID), .IN_CHAN_NUM(INC),
        .OUT_CHAN_NUM(OUTC), .CONFIRM_CYCLES(CC)
    ) dut (
        .clock(clk), .reset(rst_n),
        .proc_dep_vld_vec(pdv), .in_chan_dep_vld_vec(vld),
        .in_chan_dep_data_vec(data), .token_in_vec(tin),
        .dl_detect_in(dlin), .origin(orig), .token_clear(clr),
        .out_chan_dep_vld_vec(ovld), .out_chan_dep_data(odata),
        .token_out_vec(otok), .dl_suspect(osus), .dl_detect_out(odet),
        .dl_chan_vec(ochan), .dl_sticky(ostk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] pdv;
        logic [1:0] vld;
        logic [7:0] data;
        logic [1:0] tin;
        logic       orig;
        logic       clr;
        logic       exp_sus;
        logic [2:0] exp_tok;
        logic [3:0] exp_dep;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [2:0] p, input logic [1:0] v, input logic [7:0] d,
                          input logic [1:0] t, input logic dl, input logic o, input logic c);
        pdv = p; vld = v; data = d; tin = t; dlin = dl; orig = o; clr = c;
    endtask

    task automatic do_reset();
        set_in(3'b000, 2'b00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    // Reference model state
    int         m_dep_reg;
    int         m_run;
    bit         m_conf;
    int         m_chan;
    bit         m_sticky;
    int         m_tok;

    initial begin
        int dep_comb, dep, nd, ntok, ch;
        bit gate, raw, any_tin, blocked;

        rst_n = 1'b0;
        set_in(3'b000, 2'b00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
        #2;
        chk("async_reset_det", {31'd0, odet}, 32'd0);
        chk("async_reset_dep", {28'd0, odata}, 32'h1);
        do_reset();

        chk("reset_det", {31'd0, odet}, 32'd0);
        chk("reset_tok", {29'd0, otok}, 32'd0);
        chk("reset_chan", {29'd0, ochan}, 32'd0);
        chk("reset_sticky", {31'd0, ostk}, 32'd0);
        chk("reset_dep", {28'd0, odata}, 32'h1);

        // Continuous self-dependence: confirmation after CC cycles
        set_in(3'b001, 2'b01, 8'h01, 2'b00, 1'b0, 1'b0, 1'b0);
        #1;
        chk("seq1_suspect", {31'd0, osus}, 32'd1);
        for (int k = 0; k <= 5; k++) begin
            chk($sformatf("seq1_det_c%0d", k), {31'd0, odet}, (k >= CC) ? 32'd1 : 32'd0);
            chk($sformatf("seq1_sticky_c%0d", k), {31'd0, ostk}, (k >= CC) ? 32'd1 : 32'd0);
            if (k == CC) chk("seq1_chan", {29'd0, ochan}, 32'b001);
            tick();
        end

        // Gap at cycle 2, clear pulses, then async reset mid-SUSPECT
        do_reset();
        for (int k = 0; k <= 18; k++) begin
            set_in(3'b001, (k == 2) ? 2'b00 : 2'b01, 8'h01, 2'b00, 1'b0,
                   (k >= 16) ? 1'b1 : 1'b0, (k == 9 || k == 15) ? 1'b1 : 1'b0);
            #1;
            chk($sformatf("seq2_det_c%0d", k), {31'd0, odet},
                ((k >= 7 && k <= 9) || k == 14 || k == 15) ? 32'd1 : 32'd0);
            chk($sformatf("seq2_sticky_c%0d", k), {31'd0, ostk}, (k >= 7) ? 32'd1 : 32'd0);
            chk($sformatf("seq2_chan_c%0d", k), {29'd0, ochan}, (k >= 7) ? 32'b001 : 32'd0);
            if (k < 18) tick();
        end
        chk("seq6_tok_before", {29'd0, otok}, 32'b001);
        #1 rst_n = 1'b0;
        #1;
        chk("seq6_rst_det", {31'd0, odet}, 32'd0);
        chk("seq6_rst_tok", {29'd0, otok}, 32'd0);
        chk("seq6_rst_chan", {29'd0, ochan}, 32'd0);
        chk("seq6_rst_sticky", {31'd0, ostk}, 32'd0);
        chk("seq6_rst_dep", {28'd0, odata}, 32'h1);
        tick();
        chk("seq6_held_det", {31'd0, odet}, 32'd0);
        orig = 1'b0;
        #2 rst_n = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            tick();
            chk($sformatf("seq6_det_e%0d", j), {31'd0, odet}, (j >= CC) ? 32'd1 : 32'd0);
        end
        chk("seq6_sticky_after", {31'd0, ostk}, 32'd1);

        // dl_detect_in gating: dependence frozen until a token arrives
        do_reset();
        set_in(3'b001, 2'b01, 8'h01, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        chk("seq4_dep_loaded", {28'd0, odata}, 32'h1);
        set_in(3'b001, 2'b01, 8'h02, 2'b00, 1'b1, 1'b0, 1'b0);
        #1;
        chk("seq4_frozen_sus", {31'd0, osus}, 32'd0);
        tick();
        chk("seq4_frozen_dep", {28'd0, odata}, 32'h1);
        tin = 2'b01;
        #1;
        chk("seq4_tok_dep_now", {28'd0, odata}, 32'h1);
        tick();
        chk("seq4_tok_dep_next", {28'd0, odata}, 32'h3);

        // Table-driven vectors
        tbl[0] = '{3'b001, 2'b01, 8'h01, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 4'b0001};
        tbl[1] = '{3'b101, 2'b00, 8'hFF, 2'b00, 1'b1, 1'b0, 1'b0, 3'b101, 4'b0001};
        tbl[2] = '{3'b101, 2'b00, 8'hFF, 2'b00, 1'b1, 1'b1, 1'b0, 3'b101, 4'b0001};
        tbl[3] = '{3'b011, 2'b10, 8'h10, 2'b10, 1'b0, 1'b1, 1'b1, 3'b000, 4'b0001};
        tbl[4] = '{3'b110, 2'b11, 8'h24, 2'b01, 1'b0, 1'b0, 1'b0, 3'b110, 4'b0111};
        tbl[5] = '{3'b000, 2'b11, 8'h11, 2'b11, 1'b0, 1'b0, 1'b0, 3'b000, 4'b0001};
        tbl[6] = '{3'b010, 2'b01, 8'h0E, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 4'b1111};
        tbl[7] = '{3'b100, 2'b11, 8'h81, 2'b10, 1'b0, 1'b0, 1'b1, 3'b100, 4'b1001};
        do_reset();
        for (int v = 0; v < 8; v++) begin
            set_in(tbl[v].pdv, tbl[v].vld, tbl[v].data, tbl[v].tin, 1'b0, tbl[v].orig, tbl[v].clr);
            #1;
            chk($sformatf("tbl%0d_sus", v), {31'd0, osus}, {31'd0, tbl[v].exp_sus});
            chk($sformatf("tbl%0d_vld", v), {29'd0, ovld}, {29'd0, tbl[v].pdv});
            tick();
            chk($sformatf("tbl%0d_tok", v), {29'd0, otok}, {29'd0, tbl[v].exp_tok});
            chk($sformatf("tbl%0d_dep", v), {28'd0, odata}, {28'd0, tbl[v].exp_dep});
        end

        // Randomized run against the reference model
        do_reset();
        m_dep_reg = 0; m_run = 0; m_conf = 0; m_chan = 0; m_sticky = 0; m_tok = 0;
        for (int n = 0; n < 600; n++) begin
            pdv  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(1, 7)) : 3'b000;
            vld  = 2'($urandom);
            data = 8'($urandom);
            if ($urandom_range(0, 9) < 7) data[0] = 1'b1;
            if ($urandom_range(0, 9) < 5) data[4] = 1'b1;
            tin  = ($urandom_range(0, 9) < 3) ? 2'($urandom) : 2'b00;
            dlin = ($urandom_range(0, 9) < 2);
            orig = ($urandom_range(0, 9) < 2);
            clr  = ($urandom_range(0, 9) < 2);
            #1;
            dep_comb = 0;
            for (int i = 0; i < INC; i++)
                if (vld[i]) dep_comb = dep_comb | ((int'(data) >> (i * PN)) & 15);
            any_tin = (tin != 0);
            gate    = !dlin || any_tin;
            dep     = gate ? dep_comb : m_dep_reg;
            blocked = (pdv != 0);
            raw     = gate && ((dep >> PID) & 1) != 0 && blocked;
            chk("rnd_sus", {31'd0, osus}, {31'd0, raw});
            chk("rnd_vld", {29'd0, ovld}, {29'd0, pdv});
            chk("rnd_dep", {28'd0, odata}, 32'(m_dep_reg | (1 << PID)));
            chk("rnd_det", {31'd0, odet}, {31'd0, m_conf});
            chk("rnd_chan", {29'd0, ochan}, 32'(m_chan));
            chk("rnd_sticky", {31'd0, ostk}, {31'd0, m_sticky});
            chk("rnd_tok", {29'd0, otok}, 32'(m_tok));
            nd   = blocked ? dep : 0;
            ntok = ((any_tin && !clr) || orig) ? int'(pdv) : 0;
            ch   = int'(pdv);
            tick();
            m_dep_reg = nd;
            m_tok     = ntok;
            if (m_conf) begin
                if (clr) begin m_conf = 0; m_run = 0; end
            end else if (raw) begin
                m_run++;
                if (m_run == CC) begin
                    m_conf = 1; m_run = 0; m_chan = ch; m_sticky = 1;
                end
            end else begin
                m_run = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
